// File: rtl/sync_sweep_pkg.sv
// Shared types and constants for the synchronizer sweep controller.
package sync_sweep_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_LOAD,
      ST_STROBE,
      ST_SETTLE,
      ST_CHECK,
      ST_NEXT,
      ST_DONE
   } sweep_state_e;

   localparam logic [2:0] MODE_DIRECT       = 3'd0;
   localparam logic [2:0] MODE_NOSYNC       = 3'd1;
   localparam logic [2:0] MODE_2FF          = 3'd2;
   localparam logic [2:0] MODE_PULSE        = 3'd3;
   localparam logic [2:0] MODE_TOGGLE       = 3'd4;
   localparam logic [2:0] MODE_TOGGLE_PULSE = 3'd5;

   // Fibonacci taps for x^8+x^6+x^5+x^4+1 (register bits 7,5,4,3)
   localparam logic [7:0] LFSR_TAPS = 8'hB8;
   localparam logic [7:0] PAT_SEED  = 8'h01;

   // Lowest enabled mode at or above 'from'; bit 3 flags that one was found.
   function automatic logic [3:0] find_mode(input logic [5:0] mask, input logic [2:0] from);
      logic [3:0] res;
      res = 4'd0;
      for (int k = 5; k >= 0; k--) begin
         if (k >= int'(from) && mask[k]) res = {1'b1, 3'(k)};
      end
      return res;
   endfunction

endpackage

// File: rtl/sync_sweep_patgen.sv
// Test pattern generator for the sweep controller.
// SYNC_SWEEP_LFSR_EN selects an 8-bit Fibonacci LFSR (zero-extended to N);
// otherwise the pattern is an N-bit incrementing counter. Both seed to 1.
module sync_sweep_patgen #(
   parameter int N = 8
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         seed,
   input  logic         adv,
   output logic [N-1:0] pattern
);
   import sync_sweep_pkg::*;

`ifdef SYNC_SWEEP_LFSR_EN
   logic [7:0] lfsr_q;

   // LFSR state: seed reload has priority over advance
   always_ff @(posedge clk) begin
      if (rst) begin
         lfsr_q <= 8'h00;
      end else if (seed) begin
         lfsr_q <= PAT_SEED;
      end else if (adv) begin
         lfsr_q <= {lfsr_q[6:0], ^(lfsr_q & LFSR_TAPS)};
      end
   end

   assign pattern = N'(lfsr_q);
`else
   logic [N-1:0] cnt_q;

   // Incrementing counter: seed reload has priority, wraps all-ones to 0
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q <= '0;
      end else if (seed) begin
         cnt_q <= N'(1);
      end else if (adv) begin
         cnt_q <= cnt_q + N'(1);
      end
   end

   assign pattern = cnt_q;
`endif

endmodule

// File: rtl/sync_sweep_ctrl.sv
// Synchronizer sweep controller: walks every enabled synchronizer mode,
// drives ITERS patterns through the datapath per mode and counts failures.
// Optional build macro SYNC_SWEEP_LFSR_EN switches the pattern source to an LFSR.
module sync_sweep_ctrl #(
   parameter int N          = 8,
   parameter int ITERS      = 4,
   parameter int SETTLE_CYC = 8
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         start,
   input  logic [5:0]   mode_mask,
   input  logic [N-1:0] result_in,
   output logic [2:0]   sel,
   output logic [N-1:0] data_out,
   output logic         stb,
   output logic         busy,
   output logic         done,
   output logic [7:0]   err_cnt,
   output logic [5:0]   fail_mode
);
   import sync_sweep_pkg::*;

   localparam logic [7:0] ITERS_L     = 8'(ITERS);
   localparam logic [7:0] SETTLE_LAST = 8'(SETTLE_CYC - 1);

   sweep_state_e state_q, state_d;
   logic [5:0]   mask_q;
   logic [2:0]   mode_q;
   logic [7:0]   iter_q;
   logic [7:0]   settle_q;
   logic         seen_q;
   logic [N-1:0] pattern;
   logic         start_ok;
   logic         fail_now;
   logic [3:0]   first_mode;
   logic [3:0]   next_mode;

   function automatic logic [7:0] sat_inc8(input logic [7:0] v);
      return (v == 8'hFF) ? v : v + 8'd1;
   endfunction

   assign start_ok   = (state_q == ST_IDLE) && start;
   assign first_mode = find_mode(mode_mask, 3'd0);
   assign next_mode  = find_mode(mask_q, mode_q + 3'd1);

   assign stb  = (state_q == ST_STROBE);
   assign busy = (state_q != ST_IDLE);
   assign done = (state_q == ST_DONE);

   sync_sweep_patgen #(.N(N)) u_patgen (
      .clk     (clk),
      .rst     (rst),
      .seed    (start_ok),
      .adv     (state_q == ST_NEXT),
      .pattern (pattern)
   );

   // Failure decision for the current iteration, meaningful only in CHECK
   always_comb begin
      fail_now = 1'b0;
      if (state_q == ST_CHECK) begin
         if (mode_q == MODE_TOGGLE_PULSE) fail_now = !seen_q;
         else                             fail_now = (result_in != data_out);
      end
   end

   // State register
   always_ff @(posedge clk) begin
      if (rst) state_q <= ST_IDLE;
      else     state_q <= state_d;
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE:   if (start) state_d = (mode_mask != 6'd0) ? ST_LOAD : ST_DONE;
         ST_LOAD:   state_d = ST_STROBE;
         ST_STROBE: state_d = ST_SETTLE;
         ST_SETTLE: if (settle_q == SETTLE_LAST) state_d = ST_CHECK;
         ST_CHECK:  state_d = ST_NEXT;
         ST_NEXT:   state_d = (iter_q < ITERS_L || next_mode[3]) ? ST_LOAD : ST_DONE;
         ST_DONE:   state_d = ST_IDLE;
         default:   state_d = ST_IDLE;
      endcase
   end

   // Sweep bookkeeping: mask latch, mode/iteration walk, settle timer, pulse capture
   always_ff @(posedge clk) begin
      if (rst) begin
         mask_q   <= 6'd0;
         mode_q   <= 3'd0;
         iter_q   <= 8'd0;
         settle_q <= 8'd0;
         seen_q   <= 1'b0;
      end else begin
         if (start_ok) begin
            mask_q <= mode_mask;
            mode_q <= first_mode[2:0];
            iter_q <= 8'd1;
         end
         case (state_q)
            ST_LOAD:   seen_q <= 1'b0;
            ST_STROBE: begin
               settle_q <= 8'd0;
               if (result_in[0]) seen_q <= 1'b1;
            end
            ST_SETTLE: begin
               settle_q <= settle_q + 8'd1;
               if (result_in[0]) seen_q <= 1'b1;
            end
            ST_NEXT: begin
               if (iter_q < ITERS_L) begin
                  iter_q <= iter_q + 8'd1;
               end else if (next_mode[3]) begin
                  mode_q <= next_mode[2:0];
                  iter_q <= 8'd1;
               end
            end
            default: ;
         endcase
      end
   end

   // Datapath drive: pattern and mode select captured in LOAD, held until the next LOAD
   always_ff @(posedge clk) begin
      if (rst) begin
         sel      <= 3'd0;
         data_out <= '0;
      end else if (state_q == ST_LOAD) begin
         sel      <= mode_q;
         data_out <= pattern;
      end
   end

   // Result tracking: cleared on an accepted start, held after DONE
   always_ff @(posedge clk) begin
      if (rst || start_ok) begin
         err_cnt   <= 8'd0;
         fail_mode <= 6'd0;
      end else if (fail_now) begin
         err_cnt           <= sat_inc8(err_cnt);
         fail_mode[mode_q] <= 1'b1;
      end
   end

endmodule

// File: tb/tb_sync_sweep_ctrl.sv
// Directed testbench for sync_sweep_ctrl (default build and SYNC_SWEEP_LFSR_EN build).
module tb_sync_sweep_ctrl;
   localparam int N = 8;

   logic         clk = 1'b0;
   logic         rst, start, start2;
   logic [5:0]   mask, mask2;
   logic [N-1:0] result_in, result2;
   logic [2:0]   sel, sel2;
   logic [N-1:0] data_out, data_out2;
   logic         stb, busy, done, stb2, busy2, done2;
   logic [7:0]   err_cnt, err_cnt2;
   logic [5:0]   fail_mode, fail_mode2;

   int           rmode;
   logic [N-1:0] force_val;

   int n_checks = 0;
   int n_fail   = 0;
   int stb_cnt, done_cnt, busy_cnt, done_lat, tick_cnt;
   int sel_log [0:15];
   int dat_log [0:15];
   int exp_pat [0:3];

   always #5 clk = ~clk;

   sync_sweep_ctrl #(.N(N), .ITERS(4), .SETTLE_CYC(8)) dut (
      .clk(clk), .rst(rst), .start(start), .mode_mask(mask), .result_in(result_in),
      .sel(sel), .data_out(data_out), .stb(stb), .busy(busy), .done(done),
      .err_cnt(err_cnt), .fail_mode(fail_mode)
   );

   sync_sweep_ctrl #(.N(N), .ITERS(255), .SETTLE_CYC(8)) dut_sat (
      .clk(clk), .rst(rst), .start(start2), .mode_mask(mask2), .result_in(result2),
      .sel(sel2), .data_out(data_out2), .stb(stb2), .busy(busy2), .done(done2),
      .err_cnt(err_cnt2), .fail_mode(fail_mode2)
   );

   // 0: loopback, 1: forced constant, 2: loopback except forced 0 in mode 5
   always_comb begin
      result_in = data_out;
      if (rmode == 1)                  result_in = force_val;
      else if (rmode == 2 && sel == 3'd5) result_in = '0;
   end

   assign result2 = ~data_out2;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic clear_mon();
      stb_cnt = 0; done_cnt = 0; busy_cnt = 0; done_lat = 0; tick_cnt = 0;
      for (int i = 0; i < 16; i++) begin
         sel_log[i] = -1;
         dat_log[i] = -1;
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
      tick_cnt++;
      if (stb) begin
         if (stb_cnt < 16) begin
            sel_log[stb_cnt] = int'(sel);
            dat_log[stb_cnt] = int'(data_out);
         end
         stb_cnt++;
      end
      if (done) begin
         if (done_cnt == 0) done_lat = tick_cnt;
         done_cnt++;
      end
      if (busy && !done) busy_cnt++;
   endtask

   task automatic run_sweep(input logic [5:0] m, input int restart_at, input int budget);
      bit restarted;
      restarted = 1'b0;
      clear_mon();
      mask  = m;
      start = 1'b1;
      tick();
      start = 1'b0;
      for (int i = 0; i < budget && done_cnt == 0; i++) begin
         if (restart_at > 0 && stb_cnt == restart_at && !restarted) begin
            start     = 1'b1;
            mask      = 6'd0;
            restarted = 1'b1;
         end
         tick();
         start = 1'b0;
      end
      for (int i = 0; i < 3; i++) tick();
      chk("done_once", 32'(done_cnt), 32'd1);
   endtask

   initial begin
`ifdef SYNC_SWEEP_LFSR_EN
      exp_pat = '{1, 2, 4, 8};
`else
      exp_pat = '{1, 2, 3, 4};
`endif
      rst = 1'b1; start = 1'b0; start2 = 1'b0; mask = 6'd0; mask2 = 6'd0;
      rmode = 0; force_val = '0;
      clear_mon();
      tick(); tick();
      chk("rst_sel", 32'(sel), 32'd0);
      chk("rst_data", 32'(data_out), 32'd0);
      chk("rst_stb", 32'(stb), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_done", 32'(done), 32'd0);
      chk("rst_err", 32'(err_cnt), 32'd0);
      chk("rst_fail", 32'(fail_mode), 32'd0);

      // start coinciding with reset is discarded
      start = 1'b1; mask = 6'd1;
      tick();
      chk("rst_start_busy0", 32'(busy), 32'd0);
      rst = 1'b0; start = 1'b0;
      tick();
      chk("rst_start_busy1", 32'(busy), 32'd0);

      // Scenario 1: single mode loopback
      rmode = 0;
      run_sweep(6'b000001, 0, 200);
      chk("s1_busy_cycles", 32'(busy_cnt), 32'd48);
      chk("s1_stb_cnt", 32'(stb_cnt), 32'd4);
      chk("s1_err", 32'(err_cnt), 32'd0);
      chk("s1_fail", 32'(fail_mode), 32'd0);
      for (int i = 0; i < 4; i++) chk($sformatf("s6_pat%0d", i), 32'(dat_log[i]), 32'(exp_pat[i]));

      // Scenario 2: stuck-at-zero result in mode 2
      rmode = 1; force_val = 8'h00;
      run_sweep(6'b000100, 0, 200);
      chk("s2_err", 32'(err_cnt), 32'd4);
      chk("s2_fail", 32'(fail_mode), 32'h04);
      for (int i = 0; i < 4; i++) chk($sformatf("s2_sel%0d", i), 32'(sel_log[i]), 32'd2);
      for (int i = 0; i < 5; i++) tick();
      chk("s2_err_hold", 32'(err_cnt), 32'd4);
      chk("s2_fail_hold", 32'(fail_mode), 32'h04);

      // Scenario 3: empty mask
      run_sweep(6'b000000, 0, 10);
      chk("s3_done_lat_ok", 32'(done_lat <= 2), 32'd1);
      chk("s3_no_stb", 32'(stb_cnt), 32'd0);
      chk("s3_err_clr", 32'(err_cnt), 32'd0);

      // Scenario 4: mask skipping, restart and mask change while busy
      rmode = 2;
      run_sweep(6'b100001, 5, 300);
      chk("s4_stb_cnt", 32'(stb_cnt), 32'd8);
      for (int i = 0; i < 8; i++)
         chk($sformatf("s4_sel%0d", i), 32'(sel_log[i]), (i < 4) ? 32'd0 : 32'd5);
      chk("s4_err", 32'(err_cnt), 32'd4);
      chk("s4_fail", 32'(fail_mode), 32'h20);

      // Mode 5 with result_in[0] held high passes
      rmode = 1; force_val = 8'hFF;
      run_sweep(6'b100000, 0, 200);
      chk("m5_pass_err", 32'(err_cnt), 32'd0);
      chk("m5_pass_fail", 32'(fail_mode), 32'd0);

      // Scenario 5: reset during SETTLE of iteration 2
      rmode = 1; force_val = 8'h00;
      clear_mon();
      mask = 6'b000001; start = 1'b1;
      tick();
      start = 1'b0;
      for (int i = 0; i < 100 && stb_cnt < 2; i++) tick();
      for (int i = 0; i < 3; i++) tick();
      chk("s5_err_before", 32'(err_cnt), 32'd1);
      rst = 1'b1;
      tick();
      chk("s5_busy", 32'(busy), 32'd0);
      chk("s5_stb", 32'(stb), 32'd0);
      chk("s5_data", 32'(data_out), 32'd0);
      chk("s5_err", 32'(err_cnt), 32'd0);
      rst = 1'b0;
      for (int i = 0; i < 20; i++) tick();
      chk("s5_no_done", 32'(done_cnt), 32'd0);
      chk("s5_idle", 32'(busy), 32'd0);

      // Scenario 6b: saturation over 510 failing iterations
      mask2 = 6'b000011; start2 = 1'b1;
      tick();
      start2 = 1'b0;
      begin
         bit seen_done2;
         seen_done2 = 1'b0;
         for (int i = 0; i < 7000 && !seen_done2; i++) begin
            tick();
            if (done2) seen_done2 = 1'b1;
         end
         chk("sat_done", 32'(seen_done2), 32'd1);
      end
      chk("sat_err", 32'(err_cnt2), 32'd255);
      chk("sat_fail", 32'(fail_mode2), 32'h03);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
